sram_request_sequencer: RTL and testbench
=========================================

SRAM_REQUEST_SEQUENCER -- requirements
Module: sram_request_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, meaning SRAM word address width.
REQ-002 SHALL have parameter DATA_W, default 8, meaning SRAM data width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 2, meaning request queue entries (power of two, at least 2).
REQ-004 clk  input  1  single clock; all state on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 req_valid  input  1  host request present.
REQ-007 req_ready  output  1  queue can accept a request.
REQ-008 req_rnw  input  1  1=read, 0=write.
REQ-009 req_addr  input  ADDR_W  request address.
REQ-010 req_wdata  input  DATA_W  write data.
REQ-011 ctrl_enable  output  1  chip select to the SRAM controller.
REQ-012 ctrl_rnw  output  1  read_not_write to the SRAM controller.
REQ-013 ctrl_ready  input  1  controller ready; high in its IDLE and SENSE states.
REQ-014 op_addr  output  ADDR_W  address held stable to row/column decoders.
REQ-015 op_wdata  output  DATA_W  data held stable to write drivers.
REQ-016 sa_data  input  DATA_W  sense-amp output, valid in the controller SENSE cycle.
REQ-017 rsp_valid  output  1  one-cycle pulse per completed operation.
REQ-018 rsp_rnw  output  1  type of the completed operation.
REQ-019 rsp_rdata  output  DATA_W  read data; zero for writes.
REQ-020 seq_error  output  1  sticky lockstep-mismatch flag.

Function
REQ-021 SHALL implement an FSM with states S_IDLE, S_PRE, S_DEV, S_ACT, stepping in lockstep with the controller's IDLE/PRECHARGE/DEVELOP/SENSE states.
REQ-022 Queue: FIFO of {rnw, addr, wdata}; push on req_valid and req_ready; req_ready = not full, with no same-cycle bypass when full.
REQ-023 ctrl_enable SHALL be high combinationally in S_IDLE or S_ACT when the FIFO is non-empty, and low otherwise.
REQ-024 On any edge where ctrl_enable is high: pop the FIFO head into the op register (ctrl_rnw, op_addr, op_wdata) and go to S_PRE.
REQ-025 S_PRE goes to S_DEV; S_DEV goes to S_ACT, unconditionally.
REQ-026 S_ACT goes to S_PRE if ctrl_enable is high, else to S_IDLE; the op register is unchanged through S_PRE, S_DEV and S_ACT.
REQ-027 On the edge leaving S_ACT: register rsp_valid=1, rsp_rnw=ctrl_rnw, and rsp_rdata = sa_data if read, else 0.
REQ-028 rsp_valid SHALL deassert the following cycle unless another S_ACT ends.
REQ-029 Latency: request accepted at edge N into an empty FIFO in S_IDLE gives ctrl_enable in cycle N+1, S_PRE N+2, S_DEV N+3, S_ACT N+4, and rsp_valid in cycle N+5.
REQ-030 Back-to-back queued ops SHALL issue every 3 cycles with no idle bubble.
REQ-031 A push and a pop in the same cycle SHALL both take effect; occupancy is unchanged.
REQ-032 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-033 Lockstep check, sampled every edge: set seq_error if ctrl_ready=0 in S_IDLE or S_ACT, or if ctrl_ready=1 in S_PRE or S_DEV.
REQ-034 seq_error SHALL clear only on reset, and SHALL NOT alter sequencing.

Reset
REQ-035 rst SHALL asynchronously force state S_IDLE, FIFO empty, and pointers 0.
REQ-036 rst SHALL asynchronously clear ctrl_rnw, op_addr, op_wdata, rsp_valid, rsp_rnw, rsp_rdata and seq_error to 0.
REQ-037 Reset mid-operation SHALL abandon in-flight and queued ops with no rsp_valid; ctrl_enable is low during reset.
REQ-038 The system SHALL drive the controller rst_n from ~rst so both blocks leave reset on the same edge.

Structure
REQ-039 A shared package SHALL hold the state encoding (2 bits, matching the controller order), default ADDR_W/DATA_W, and the request record layout.
REQ-040 The FIFO SHALL be a sub-module, sram_req_fifo (push/pop/full/empty/head).

Verification
REQ-041 Single read, addr=0x5, sa_data=0xA3 in S_ACT -> rsp_valid in cycle N+5, rsp_rnw=1, rsp_rdata=0xA3.
REQ-042 Write addr=0xF, wdata=0x3C -> op_addr=0xF and op_wdata=0x3C stable for three cycles, ctrl_rnw=0, rsp_rdata=0x00.
REQ-043 Three requests pushed on consecutive cycles -> req_ready low when full, ops issue 3 cycles apart, three rsp_valid pulses 3 cycles apart, ctrl_enable low after the last S_ACT.
REQ-044 Push during the S_ACT of the last queued op -> ctrl_enable stays low that cycle and the new op starts from S_IDLE.
REQ-045 rst pulsed during S_DEV with 2 queued -> all outputs 0 immediately and no rsp_valid afterwards.
REQ-046 ctrl_ready forced 0 during S_ACT -> seq_error=1 persists until rst.

Source files
------------

// File: rtl/sram_request_sequencer_pkg.sv
// Shared definitions for the SRAM request sequencer: controller-ordered state
// encoding, default widths and the packed request record layout.
package sram_request_sequencer_pkg;

  // Encoding follows the controller: IDLE, PRECHARGE, DEVELOP, SENSE.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_DEV  = 2'd2,
    S_ACT  = 2'd3
  } seq_state_e;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 8;

  // Request record is {rnw, addr, wdata}, wdata in the least significant bits.
  function automatic int req_rec_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/sram_req_fifo.sv
// Request queue for the SRAM sequencer; power-of-two depth, pointers wrap
// naturally, head is visible combinationally so a pop can load it on the same edge.
module sram_req_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             do_push, do_pop;

  assign full    = (count_reg == FULL_CNT);
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/sram_request_sequencer.sv
// Queues host SRAM requests and issues them to the SRAM controller, stepping in
// lockstep with its IDLE/PRECHARGE/DEVELOP/SENSE phases and returning one response per op.
module sram_request_sequencer
  import sram_request_sequencer_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rnw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              ctrl_enable,
  output logic              ctrl_rnw,
  input  logic              ctrl_ready,
  output logic [ADDR_W-1:0] op_addr,
  output logic [DATA_W-1:0] op_wdata,
  input  logic [DATA_W-1:0] sa_data,
  output logic              rsp_valid,
  output logic              rsp_rnw,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              seq_error
);

  localparam int REC_W = req_rec_w(ADDR_W, DATA_W);

  seq_state_e       state_reg, state_next;
  logic             fifo_full, fifo_empty;
  logic             push;
  logic [REC_W-1:0] fifo_head;
  logic             issue_slot;
  logic             lockstep_bad;

  // No bypass: a full queue refuses even when it pops this cycle.
  assign req_ready   = !fifo_full;
  assign push        = req_valid && req_ready;
  assign issue_slot  = (state_reg == S_IDLE) || (state_reg == S_ACT);
  assign ctrl_enable = issue_slot && !fifo_empty;

  sram_req_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (ctrl_enable),
    .din   ({req_rnw, req_addr, req_wdata}),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (ctrl_enable) state_next = S_PRE;
      S_PRE:   state_next = S_DEV;
      S_DEV:   state_next = S_ACT;
      S_ACT:   state_next = ctrl_enable ? S_PRE : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Controller must report ready exactly in its IDLE and SENSE phases.
  assign lockstep_bad = issue_slot ? !ctrl_ready : ctrl_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      ctrl_rnw  <= 1'b0;
      op_addr   <= '0;
      op_wdata  <= '0;
      rsp_valid <= 1'b0;
      rsp_rnw   <= 1'b0;
      rsp_rdata <= '0;
      seq_error <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (ctrl_enable) begin
        ctrl_rnw <= fifo_head[REC_W-1];
        op_addr  <= fifo_head[DATA_W +: ADDR_W];
        op_wdata <= fifo_head[DATA_W-1:0];
      end
      rsp_valid <= (state_reg == S_ACT);
      if (state_reg == S_ACT) begin
        rsp_rnw   <= ctrl_rnw;
        rsp_rdata <= ctrl_rnw ? sa_data : '0;
      end
      if (lockstep_bad) seq_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_request_sequencer.sv
// Randomized self-checking bench: a transaction-level schedule model predicts
// issue/response cycles, queue occupancy and op/response contents.
module tb_sram_request_sequencer;

  localparam int AW     = 4;
  localparam int DW     = 8;
  localparam int DEPTH  = 2;
  localparam int MAXOPS = 1024;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_rnw;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          ctrl_enable, ctrl_rnw, ctrl_ready;
  logic [AW-1:0] op_addr;
  logic [DW-1:0] op_wdata, sa_data;
  logic          rsp_valid, rsp_rnw;
  logic [DW-1:0] rsp_rdata;
  logic          seq_error;

  always #5 clk = ~clk;

  sram_request_sequencer #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_rnw(req_rnw),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .ctrl_enable(ctrl_enable), .ctrl_rnw(ctrl_rnw), .ctrl_ready(ctrl_ready),
    .op_addr(op_addr), .op_wdata(op_wdata), .sa_data(sa_data),
    .rsp_valid(rsp_valid), .rsp_rnw(rsp_rnw), .rsp_rdata(rsp_rdata),
    .seq_error(seq_error)
  );

  // Model: op k accepted at the edge ending cycle acc, enabled during cycle iss,
  // PRE/DEV/ACT in iss+1..iss+3, response visible in cycle iss+4.
  int            op_n;
  int            op_acc [MAXOPS];
  int            op_iss [MAXOPS];
  bit            op_rnw [MAXOPS];
  logic [AW-1:0] op_ad  [MAXOPS];
  logic [DW-1:0] op_wd  [MAXOPS];
  logic [DW-1:0] op_rd  [MAXOPS];
  int            last_iss;
  logic [AW+DW:0] send_q[$];

  int   cyc;
  int   checks = 0;
  int   failures = 0;
  bit   exp_err, err_pending, break_ready;
  bit   sa_fix_en;
  logic [DW-1:0] sa_fix;
  bit   exp_ready;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int find_op(input int c, input int off);
    for (int k = 0; k < op_n; k++)
      if (op_iss[k] + off == c) return k;
    return -1;
  endfunction

  function automatic int occupancy(input int c);
    int n = 0;
    for (int k = 0; k < op_n; k++)
      if (op_acc[k] < c && op_iss[k] >= c) n++;
    return n;
  endfunction

  task automatic model_clear();
    op_n = 0;
    last_iss = -100;
    send_q.delete();
    exp_err = 0;
    err_pending = 0;
  endtask

  task automatic cycle();
    int k;
    @(posedge clk);
    #1;
    cyc++;
    if (err_pending) begin
      exp_err = 1;
      err_pending = 0;
    end
    if (send_q.size() > 0) begin
      {req_rnw, req_addr, req_wdata} = send_q[0];
      req_valid = 1'b1;
    end else begin
      req_valid = 1'b0;
      {req_rnw, req_addr, req_wdata} = (AW + DW + 1)'($urandom);
    end
    sa_data = sa_fix_en ? sa_fix : DW'($urandom);
    ctrl_ready = !(find_op(cyc, 1) >= 0 || find_op(cyc, 2) >= 0);
    if (break_ready && find_op(cyc, 3) >= 0) begin
      ctrl_ready = 1'b0;
      err_pending = 1;
      break_ready = 0;
    end
    exp_ready = occupancy(cyc) < DEPTH;
    k = find_op(cyc, 3);
    if (k >= 0) op_rd[k] = op_rnw[k] ? sa_data : '0;

    @(negedge clk);
    check("req_ready", req_ready, exp_ready);
    check("ctrl_enable", ctrl_enable, find_op(cyc, 0) >= 0);
    check("seq_error", seq_error, exp_err);
    for (int off = 1; off <= 3; off++) begin
      k = find_op(cyc, off);
      if (k >= 0) begin
        check("ctrl_rnw", ctrl_rnw, op_rnw[k]);
        check("op_addr", op_addr, op_ad[k]);
        check("op_wdata", op_wdata, op_wd[k]);
      end
    end
    k = find_op(cyc, 4);
    if (k >= 0) begin
      check("rsp_valid", rsp_valid, 1);
      check("rsp_rnw", rsp_rnw, op_rnw[k]);
      check("rsp_rdata", rsp_rdata, op_rd[k]);
      $display("cyc=%0d RSP rnw=%0d rdata=0x%02h", cyc, rsp_rnw, rsp_rdata);
    end else begin
      check("rsp_idle", rsp_valid, 0);
    end

    if (req_valid && exp_ready && op_n < MAXOPS) begin
      op_acc[op_n] = cyc;
      op_iss[op_n] = (cyc + 1 > last_iss + 3) ? cyc + 1 : last_iss + 3;
      op_rnw[op_n] = req_rnw;
      op_ad[op_n]  = req_addr;
      op_wd[op_n]  = req_wdata;
      op_rd[op_n]  = '0;
      last_iss = op_iss[op_n];
      op_n++;
      void'(send_q.pop_front());
      $display("cyc=%0d REQ rnw=%0d addr=0x%0h wdata=0x%02h", cyc, req_rnw, req_addr, req_wdata);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_enable"}, ctrl_enable, 0);
    check({tag, "_ctrl_rnw"}, ctrl_rnw, 0);
    check({tag, "_op_addr"}, op_addr, 0);
    check({tag, "_op_wdata"}, op_wdata, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_rnw"}, rsp_rnw, 0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 0);
    check({tag, "_seq_error"}, seq_error, 0);
    check({tag, "_req_ready"}, req_ready, 1);
  endtask

  // Asynchronous reset asserted mid-cycle, released away from any clock edge.
  task automatic reset_mid(input string tag);
    req_valid = 1'b0;
    #1 rst = 1'b1;
    #1 check_all_zero(tag);
    model_clear();
    @(posedge clk);
    #2 rst = 1'b0;
    ctrl_ready = 1'b1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic drain();
    int guard = 0;
    while ((send_q.size() > 0 || last_iss + 4 >= cyc) && guard < 200) begin
      cycle();
      guard++;
    end
    check("drain_bound", guard < 200, 1);
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    req_valid = 1'b0;
    req_rnw = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    ctrl_ready = 1'b1;
    sa_data = '0;
    cyc = 0;
    break_ready = 0;
    sa_fix_en = 0;
    sa_fix = '0;
    model_clear();

    #12 check_all_zero("reset");
    @(posedge clk);
    #2 rst = 1'b0;

    // Single read, sense data 0xA3.
    sa_fix_en = 1;
    sa_fix = 8'hA3;
    send_q.push_back({1'b1, 4'h5, 8'h00});
    run(8);

    // Single write, address 0xF, data 0x3C.
    sa_fix_en = 0;
    send_q.push_back({1'b0, 4'hF, 8'h3C});
    run(8);

    // Three requests on consecutive cycles fill the queue.
    send_q.push_back({1'b1, 4'h1, 8'h11});
    send_q.push_back({1'b0, 4'h2, 8'h22});
    send_q.push_back({1'b1, 4'h3, 8'h33});
    run(16);

    // New request arriving during the SENSE of the last queued op.
    send_q.push_back({1'b1, 4'h7, 8'h00});
    guard = 0;
    while (find_op(cyc + 1, 3) < 0 && guard < 20) begin
      cycle();
      guard++;
    end
    check("act_found", guard < 20, 1);
    send_q.push_back({1'b0, 4'h8, 8'h5A});
    run(10);

    // Reset during DEVELOP with two requests still queued.
    send_q.push_back({1'b1, 4'h9, 8'h00});
    send_q.push_back({1'b0, 4'hA, 8'h77});
    send_q.push_back({1'b1, 4'hB, 8'h00});
    guard = 0;
    do begin
      cycle();
      guard++;
    end while (!(find_op(cyc, 2) >= 0 && occupancy(cyc) == 2) && guard < 20);
    check("dev_found", guard < 20, 1);
    reset_mid("rst_dev");
    run(10);

    // Randomized traffic.
    for (int i = 0; i < 700; i++) begin
      if (send_q.size() == 0 && $urandom_range(0, 99) < 45) begin
        send_q.push_back((AW + DW + 1)'($urandom));
        if ($urandom_range(0, 3) == 0) send_q.push_back((AW + DW + 1)'($urandom));
      end
      cycle();
    end
    drain();

    // Lockstep violation during SENSE sets a sticky error.
    break_ready = 1;
    send_q.push_back({1'b1, 4'hC, 8'h00});
    run(8);
    send_q.push_back({1'b0, 4'hD, 8'h99});
    run(10);
    check("seq_err_sticky", seq_error, 1);
    reset_mid("rst_err");
    run(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
